mc_cpu_core: RTL and testbench
==============================

# mc_cpu_core

Parametrised multicycle processor core, the next generation of the team's 8-bit teaching CPU. The core keeps the same 8-bit instruction set, 4-entry register file and N/Z flags. Its data path is widened to DW bits, and it talks to memory through a request/ready handshake, so memory may insert wait states. It adds a HALT instruction and a debug register read port. The core sits between the board top level (clock, reset, debug display) and a single shared instruction/data memory.

## Interface
- DW, 8: data, register, PC and address width; legal values are 8 or more.
- RESET_PC, 0: PC value loaded on reset.
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high.
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  DW  access address.
- mem_wdata  out  DW  store data.
- mem_rdata  in  DW  read data; valid in the cycle where mem_req and mem_ready are both high.
- mem_ready  in  1  access completes at the edge where mem_req and mem_ready are both high.
- dbg_sel  in  2  selects the register shown on dbg_data.
- dbg_data  out  DW  combinational read of register r[dbg_sel].
- pc  out  DW  current PC.
- flag_n, flag_z  out  1  the N and Z flags.
- halted  out  1  high while the core is in HALT.
- instret  out  32  count of retired instructions (see Configuration).

## Operation
- Instruction fields: opcode = IR[3:0], R1 = IR[7:6], R2 = IR[5:4]. The IR is loaded from mem_rdata[7:0].
- Instruction set:
  - 0000 load: R1 ← M[R2].
  - 0010 store: M[R2] ← R1.
  - 0100 add: R1 ← R1+R2.
  - 0110 sub: R1 ← R1−R2.
  - 1000 nand: R1 ← ~(R1&R2).
  - x111 ori: r1 ← r1 | zext(IR[7:3]).
  - x011 shift: R1 shifted by IR[4:3] positions; IR[5]=0 shifts left, IR[5]=1 shifts right (logical).
  - 0101 bz, 1001 bnz, 1101 bpz: if Z / !Z / !N respectively, PC ← PC + sext(IR[7:4]). PC here is the already-incremented PC.
  - 0001 halt.
  - 1010, 1100, 1110: nop.
- Arithmetic is modulo 2^DW.
- Flags: add, sub, nand, ori and shift write N = result[DW−1] and Z = (result == 0). No other instruction changes the flags.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. When ready: IR ← rdata[7:0], PC ← PC+1, go to DECODE.
  - DECODE: latch operands A ← r[R1] and B ← r[R2] (for ori, A ← r1). halt → HALT. nop → FETCH. Otherwise → EXEC.
  - EXEC: ALU instructions latch the result and go to WB. Branches update PC if taken, then → FETCH. Load/store → MEM.
  - MEM: mem_req=1, mem_addr=B, mem_we=1 for store with mem_wdata=A. Held until ready. A load latches rdata, then → WB; a store → FETCH.
  - WB: register write, then → FETCH.
  - HALT: absorbing; only reset leaves it.
- Instruction cost with zero wait states: branch 3 cycles, ALU 4, store 4, load 5, nop 2. halt reaches HALT after 2 cycles.
- Every wait cycle adds exactly 1 cycle. mem_addr, mem_we and mem_wdata stay stable while mem_req=1 and mem_ready=0.
- Writes to r0 are normal; r0 is not hardwired to zero.

## Timing
- Reset values: PC=RESET_PC; registers, IR, A, B and the flags are 0; state=FETCH; halted=0; instret=0.
- mem_req is a registered-state decode. It is high in the first cycle after reset deasserts.
- Reset asserted mid-access (in FETCH or MEM while waiting) drops mem_req immediately. No register or memory write takes effect.
- mem_ready while mem_req=0 is ignored.
- dbg_data and pc are combinational from the register state. There is no added latency.
- PC wraps from 2^DW−1 to 0.

## Configuration
- MC_CPU_INSTRET_EN defined: instret increments by 1 at each retirement.
  - A retirement is the final cycle of each instruction: the transition to FETCH, or DECODE→HALT for halt.
  - The counter wraps at 2^32.
- MC_CPU_INSTRET_EN undefined: instret is tied to 0 and no counter flops are built.

## Structure
- Package mc_cpu_pkg holds:
  - the opcode localparams;
  - the state enum typedef;
  - a function that decodes an opcode into its instruction class.
- Sub-module mc_regfile: 4×DW registers, two combinational read ports plus a debug read port, one synchronous write port, asynchronous clear.

## Test plan
- DW=8, memory holds 0x2F, 0x54, 0x01, mem_ready tied to 1 → r1=0x0A, Z=0, N=0, halted=1, pc=0x03, instret=3.
- Memory holds 0x56, 0x15, 0x0F, 0x01 → sub sets Z=1, bz skips address 0x02, r1=0x00, pc=0x04.
- Program 1 with mem_ready low for 3 cycles on every access → same final state. mem_addr is stable during each wait, and total cycles grow by 3 per access.
- Memory holds 0x3F, 0x42, 0x80, 0x01 → a write to address 0x00 with data 0x07 is seen on the bus, then r2=0x07. The load takes 5 cycles.
- Reset asserted during a MEM wait of a store → mem_req drops in the same cycle, no write occurs, and fetch restarts at RESET_PC.
- DW=16, memory holds 0x0F, 0x16, 0x01 → r0=0xFFFF, N=1, Z=0.

Source files
------------

// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the mc_cpu_core multicycle processor: opcodes,
// FSM states and the opcode-to-instruction-class decoder.
package mc_cpu_pkg;

    localparam int NUM_REGS = 4;
    localparam int REG_AW   = 2;

    localparam logic [3:0] OP_LOAD  = 4'b0000;
    localparam logic [3:0] OP_HALT  = 4'b0001;
    localparam logic [3:0] OP_STORE = 4'b0010;
    localparam logic [3:0] OP_ADD   = 4'b0100;
    localparam logic [3:0] OP_BZ    = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_NAND  = 4'b1000;
    localparam logic [3:0] OP_BNZ   = 4'b1001;
    localparam logic [3:0] OP_BPZ   = 4'b1101;

    // ori and shift are matched on the low three opcode bits only
    localparam logic [2:0] OP_ORI_LOW   = 3'b111;
    localparam logic [2:0] OP_SHIFT_LOW = 3'b011;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_LOAD,
        CLS_STORE,
        CLS_ALU,
        CLS_BRANCH,
        CLS_HALT,
        CLS_NOP
    } iclass_t;

    function automatic iclass_t decode_class(input logic [3:0] op);
        iclass_t cls;
        cls = CLS_NOP;
        if (op[2:0] == OP_ORI_LOW || op[2:0] == OP_SHIFT_LOW) begin
            cls = CLS_ALU;
        end else begin
            case (op)
                OP_LOAD:                 cls = CLS_LOAD;
                OP_STORE:                cls = CLS_STORE;
                OP_ADD, OP_SUB, OP_NAND: cls = CLS_ALU;
                OP_BZ, OP_BNZ, OP_BPZ:   cls = CLS_BRANCH;
                OP_HALT:                 cls = CLS_HALT;
                default:                 cls = CLS_NOP;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/mc_cpu_core_regfile.sv
// Four-entry register file: two operand read ports, a debug read port,
// one synchronous write port and asynchronous clear.
module mc_regfile
    import mc_cpu_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DW-1:0]     wdata,
    input  logic [REG_AW-1:0] raddr_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DW-1:0]     rdata_a,
    output logic [DW-1:0]     rdata_b,
    input  logic [REG_AW-1:0] dbg_sel,
    output logic [DW-1:0]     dbg_data
);

    logic [DW-1:0] regs [NUM_REGS];

    // r0 is an ordinary register; nothing is hardwired
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a  = regs[raddr_a];
    assign rdata_b  = regs[raddr_b];
    assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/mc_cpu_core.sv
// Multicycle 8-bit-ISA core with a DW-bit datapath and req/ready memory port.
// Define MC_CPU_INSTRET_EN to build the retired-instruction counter.
module mc_cpu_core
    import mc_cpu_pkg::*;
#(
    parameter int            DW       = 8,
    parameter logic [DW-1:0] RESET_PC = '0
) (
    input  logic          clock,
    input  logic          reset,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    input  logic [1:0]    dbg_sel,
    output logic [DW-1:0] dbg_data,
    output logic [DW-1:0] pc,
    output logic          flag_n,
    output logic          flag_z,
    output logic          halted,
    output logic [31:0]   instret
);

    state_t        state;
    state_t        next_state;
    iclass_t       cls;
    logic [7:0]    ir;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] result;
    logic [DW-1:0] rd_a;
    logic [DW-1:0] rd_b;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] branch_offset;
    logic [1:0]    dest;
    logic          is_ori;
    logic          is_shift;
    logic          branch_taken;
    logic          rf_we;

    assign cls      = decode_class(ir[3:0]);
    assign is_ori   = (ir[2:0] == OP_ORI_LOW);
    assign is_shift = (ir[2:0] == OP_SHIFT_LOW);
    // ori has no register field free, so it always targets r1
    assign dest     = is_ori ? 2'd1 : ir[7:6];
    assign rf_we    = (state == WB);

    mc_regfile #(.DW(DW)) u_regfile (
        .clock    (clock),
        .reset    (reset),
        .we       (rf_we),
        .waddr    (dest),
        .wdata    (result),
        .raddr_a  (dest),
        .raddr_b  (ir[5:4]),
        .rdata_a  (rd_a),
        .rdata_b  (rd_b),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    always_comb begin
        alu_result = '0;
        if (is_ori) begin
            alu_result = a | DW'(ir[7:3]);
        end else if (is_shift) begin
            alu_result = ir[5] ? (a >> ir[4:3]) : (a << ir[4:3]);
        end else begin
            case (ir[3:0])
                OP_ADD:  alu_result = a + b;
                OP_SUB:  alu_result = a - b;
                OP_NAND: alu_result = ~(a & b);
                default: alu_result = '0;
            endcase
        end
    end

    always_comb begin
        branch_taken = 1'b0;
        case (ir[3:0])
            OP_BZ:   branch_taken = flag_z;
            OP_BNZ:  branch_taken = !flag_z;
            OP_BPZ:  branch_taken = !flag_n;
            default: branch_taken = 1'b0;
        endcase
    end

    assign branch_offset = {{(DW-4){ir[7]}}, ir[7:4]};

    // Reset gates the request so an in-flight access is abandoned at once
    assign mem_req   = !reset && (state == FETCH || state == MEM);
    assign mem_we    = (state == MEM) && (cls == CLS_STORE);
    assign mem_addr  = (state == MEM) ? b : pc;
    assign mem_wdata = a;
    assign halted    = (state == HALT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH: begin
                if (mem_ready) next_state = DECODE;
            end
            DECODE: begin
                case (cls)
                    CLS_HALT: next_state = HALT;
                    CLS_NOP:  next_state = FETCH;
                    default:  next_state = EXEC;
                endcase
            end
            EXEC: begin
                case (cls)
                    CLS_ALU:               next_state = WB;
                    CLS_LOAD, CLS_STORE:   next_state = MEM;
                    default:               next_state = FETCH;
                endcase
            end
            MEM: begin
                if (mem_ready) next_state = (cls == CLS_STORE) ? FETCH : WB;
            end
            WB:      next_state = FETCH;
            HALT:    next_state = HALT;
            default: next_state = FETCH;
        endcase
    end

    // PC, IR, operand latches, result and flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            result <= '0;
            flag_n <= 1'b0;
            flag_z <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (mem_ready) begin
                        ir <= mem_rdata[7:0];
                        pc <= pc + DW'(1);
                    end
                end
                DECODE: begin
                    a <= rd_a;
                    b <= rd_b;
                end
                EXEC: begin
                    if (cls == CLS_ALU) begin
                        result <= alu_result;
                        flag_n <= alu_result[DW-1];
                        flag_z <= (alu_result == '0);
                    end else if (cls == CLS_BRANCH && branch_taken) begin
                        pc <= pc + branch_offset;
                    end
                end
                MEM: begin
                    if (mem_ready && cls == CLS_LOAD) result <= mem_rdata;
                end
                default: ;
            endcase
        end
    end

`ifdef MC_CPU_INSTRET_EN
    logic        retire;
    logic [31:0] instret_count;

    // An instruction retires on its last cycle: back to FETCH, or into HALT
    assign retire = (next_state == FETCH && state != FETCH) ||
                    (next_state == HALT && state == DECODE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instret_count <= '0;
        end else if (retire) begin
            instret_count <= instret_count + 32'd1;
        end
    end

    assign instret = instret_count;
`else
    assign instret = '0;
`endif

endmodule

// File: tb/tb_mc_cpu_core.sv
// Self-checking bench for mc_cpu_core: directed programs plus random programs
// compared against an instruction-level reference model.
module tb_mc_cpu_core;

`ifdef MC_CPU_INSTRET_EN
    localparam bit INSTRET_ON = 1'b1;
`else
    localparam bit INSTRET_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ready;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata, dbg_data, pc;
    logic [1:0]  dbg_sel = 2'd0;
    logic        flag_n, flag_z, halted;
    logic [31:0] instret;

    logic        req16, we16, n16, z16, halted16;
    logic        ready16;
    logic [15:0] addr16, wdata16, rdata16, dbg16, pc16;
    logic [1:0]  dbg_sel16 = 2'd0;
    logic [31:0] instret16;

    logic [7:0]  mem [256];
    logic [7:0]  img [256];
    logic [15:0] mem16 [16];
    logic [7:0]  wr_addr_q [$];
    logic [7:0]  wr_data_q [$];

    logic [7:0]  m_mem [256];
    logic [7:0]  m_reg [4];
    logic        m_n, m_z;
    logic [7:0]  m_pc;
    int          m_cycles, m_retired;

    int ready_mode = 0;
    int wait_cnt = 0;
    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    mc_cpu_core #(.DW(8), .RESET_PC(8'h00)) dut (
        .clock(clock), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .dbg_sel(dbg_sel), .dbg_data(dbg_data), .pc(pc),
        .flag_n(flag_n), .flag_z(flag_z), .halted(halted), .instret(instret)
    );

    mc_cpu_core #(.DW(16), .RESET_PC(16'h0000)) dut16 (
        .clock(clock), .reset(reset), .mem_req(req16), .mem_we(we16),
        .mem_addr(addr16), .mem_wdata(wdata16), .mem_rdata(rdata16),
        .mem_ready(ready16), .dbg_sel(dbg_sel16), .dbg_data(dbg16), .pc(pc16),
        .flag_n(n16), .flag_z(z16), .halted(halted16), .instret(instret16)
    );

    assign mem_rdata = mem[mem_addr];
    assign rdata16   = (addr16 < 16'd16) ? mem16[addr16[3:0]] : 16'h0001;
    assign ready16   = 1'b1;

    always @(posedge clock) begin
        if (!reset && mem_req && mem_ready && mem_we) begin
            mem[mem_addr] = mem_wdata;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
        if (!reset && req16 && we16 && addr16 < 16'd16) mem16[addr16[3:0]] = wdata16;
    end

    // Mode 0: always ready, 1: random, 2: three wait cycles per access
    always @(negedge clock) begin
        if (reset) begin
            wait_cnt  = 0;
            mem_ready = (ready_mode == 0);
        end else if (ready_mode == 0) begin
            mem_ready = 1'b1;
        end else if (ready_mode == 1) begin
            mem_ready = ($urandom_range(0, 1) == 1);
        end else if (mem_req && wait_cnt < 3) begin
            mem_ready = 1'b0;
            wait_cnt  = wait_cnt + 1;
        end else begin
            mem_ready = mem_req;
            wait_cnt  = 0;
        end
    end

    task automatic fill_img();
        foreach (img[i]) img[i] = 8'h01;
    endtask

    task automatic reset_and_load();
        reset = 1'b1;
        wr_addr_q.delete();
        wr_data_q.delete();
        @(posedge clock);
        #1;
        foreach (img[i]) mem[i] = img[i];
        @(posedge clock);
        #2 reset = 1'b0;
    endtask

    task automatic run_program(input int budget, output int cycles, output int waits,
                               output int unstable, output bit timeout);
        logic       prev_wait;
        logic [7:0] s_addr, s_wdata;
        logic       s_we;
        cycles = 0; waits = 0; unstable = 0; timeout = 1'b1; prev_wait = 1'b0;
        s_addr = '0; s_wdata = '0; s_we = 1'b0;
        while (cycles < budget) begin
            @(negedge clock);
            #1;
            if (prev_wait && mem_req &&
                (mem_addr !== s_addr || mem_we !== s_we || mem_wdata !== s_wdata))
                unstable++;
            prev_wait = mem_req && !mem_ready;
            if (prev_wait) waits++;
            s_addr = mem_addr; s_we = mem_we; s_wdata = mem_wdata;
            @(posedge clock);
            cycles++;
            #1;
            if (halted) begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    // Instruction-level interpreter; cycle cost is tallied per instruction class
    task automatic model_run(input int limit, output bit done);
        logic [7:0] ins, va, vb, res;
        bit         wr_flags, taken;
        foreach (m_reg[i]) m_reg[i] = 8'h00;
        m_pc = 8'h00; m_n = 1'b0; m_z = 1'b0; m_cycles = 0; m_retired = 0; done = 1'b0;
        for (int k = 0; k < limit && !done; k++) begin
            ins = m_mem[m_pc];
            m_pc = m_pc + 8'd1;
            m_retired++;
            va = m_reg[ins[7:6]];
            vb = m_reg[ins[5:4]];
            wr_flags = 1'b0;
            res = 8'h00;
            if (ins[2:0] == 3'b111) begin
                res = m_reg[1] | {3'b000, ins[7:3]};
                m_reg[1] = res; wr_flags = 1'b1; m_cycles += 4;
            end else if (ins[2:0] == 3'b011) begin
                res = ins[5] ? (va >> ins[4:3]) : (va << ins[4:3]);
                m_reg[ins[7:6]] = res; wr_flags = 1'b1; m_cycles += 4;
            end else begin
                case (ins[3:0])
                    4'd0: begin m_reg[ins[7:6]] = m_mem[vb]; m_cycles += 5; end
                    4'd2: begin m_mem[vb] = va; m_cycles += 4; end
                    4'd4, 4'd6, 4'd8: begin
                        if (ins[3:0] == 4'd4)      res = va + vb;
                        else if (ins[3:0] == 4'd6) res = va - vb;
                        else                       res = ~(va & vb);
                        m_reg[ins[7:6]] = res; wr_flags = 1'b1; m_cycles += 4;
                    end
                    4'd5, 4'd9, 4'd13: begin
                        if (ins[3:0] == 4'd5)      taken = m_z;
                        else if (ins[3:0] == 4'd9) taken = !m_z;
                        else                       taken = !m_n;
                        if (taken) m_pc = m_pc + {{4{ins[7]}}, ins[7:4]};
                        m_cycles += 3;
                    end
                    4'd1:    begin done = 1'b1; m_cycles += 2; end
                    default: m_cycles += 2;
                endcase
            end
            if (wr_flags) begin
                m_n = res[7];
                m_z = (res == 8'h00);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ready_mode = 0;
        fill_img();
        foreach (img[i]) mem[i] = img[i];
        repeat (2) @(posedge clock);
        #1;
        checks++; if (mem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", mem_req); else passed++;
        checks++; if (pc !== 8'h00) $display("FAIL rst_pc: got %h want 00", pc); else passed++;
        checks++; if (halted !== 1'b0) $display("FAIL rst_halted: got %b want 0", halted); else passed++;
        checks++; if ({flag_n, flag_z} !== 2'b00) $display("FAIL rst_flags: got %b want 00", {flag_n, flag_z}); else passed++;
        checks++; if (instret !== 32'd0) $display("FAIL rst_instret: got %0d want 0", instret); else passed++;
        for (int i = 0; i < 4; i++) begin
            dbg_sel = i[1:0];
            #1;
            checks++; if (dbg_data !== 8'h00) $display("FAIL rst_r%0d: got %h want 00", i, dbg_data); else passed++;
        end
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h00)
            $display("FAIL rst_first_fetch: got req=%b we=%b addr=%h want 1 0 00", mem_req, mem_we, mem_addr);
        else passed++;
    endtask

    task automatic test_alu_program();
        int cyc, w, u; bit to;
        logic [7:0] exp_r [4];
        fill_img();
        img[0] = 8'h2F; img[1] = 8'h54; img[2] = 8'h01;
        ready_mode = 0;
        reset_and_load();
        run_program(200, cyc, w, u, to);
        exp_r[0] = 8'h00; exp_r[1] = 8'h0A; exp_r[2] = 8'h00; exp_r[3] = 8'h00;
        checks++; if (to) $display("FAIL alu_timeout: got no halt want halt"); else passed++;
        checks++; if (cyc != 10) $display("FAIL alu_cycles: got %0d want 10", cyc); else passed++;
        for (int i = 0; i < 4; i++) begin
            dbg_sel = i[1:0];
            #1;
            checks++; if (dbg_data !== exp_r[i]) $display("FAIL alu_r%0d: got %h want %h", i, dbg_data, exp_r[i]); else passed++;
        end
        checks++; if ({flag_n, flag_z} !== 2'b00) $display("FAIL alu_flags: got %b want 00", {flag_n, flag_z}); else passed++;
        checks++; if (pc !== 8'h03) $display("FAIL alu_pc: got %h want 03", pc); else passed++;
        checks++; if (instret !== (INSTRET_ON ? 32'd3 : 32'd0)) $display("FAIL alu_instret: got %0d want %0d", instret, INSTRET_ON ? 3 : 0); else passed++;
    endtask

    task automatic test_branch();
        int cyc, w, u; bit to;
        fill_img();
        img[0] = 8'h56; img[1] = 8'h15; img[2] = 8'h0F; img[3] = 8'h01;
        ready_mode = 0;
        reset_and_load();
        run_program(200, cyc, w, u, to);
        dbg_sel = 2'd1;
        #1;
        checks++; if (to) $display("FAIL bz_timeout: got no halt want halt"); else passed++;
        checks++; if (cyc != 9) $display("FAIL bz_cycles: got %0d want 9", cyc); else passed++;
        checks++; if (dbg_data !== 8'h00) $display("FAIL bz_r1: got %h want 00", dbg_data); else passed++;
        checks++; if ({flag_n, flag_z} !== 2'b01) $display("FAIL bz_flags: got %b want 01", {flag_n, flag_z}); else passed++;
        checks++; if (pc !== 8'h04) $display("FAIL bz_pc: got %h want 04", pc); else passed++;
    endtask

    task automatic test_wait_states();
        int cyc, w, u; bit to;
        fill_img();
        img[0] = 8'h2F; img[1] = 8'h54; img[2] = 8'h01;
        ready_mode = 2;
        reset_and_load();
        run_program(400, cyc, w, u, to);
        ready_mode = 0;
        dbg_sel = 2'd1;
        #1;
        checks++; if (to) $display("FAIL wait_timeout: got no halt want halt"); else passed++;
        checks++; if (cyc != 19) $display("FAIL wait_cycles: got %0d want 19", cyc); else passed++;
        checks++; if (w != 9) $display("FAIL wait_count: got %0d want 9", w); else passed++;
        checks++; if (u != 0) $display("FAIL wait_bus_stable: got %0d changes want 0", u); else passed++;
        checks++; if (dbg_data !== 8'h0A) $display("FAIL wait_r1: got %h want 0a", dbg_data); else passed++;
        checks++; if (pc !== 8'h03) $display("FAIL wait_pc: got %h want 03", pc); else passed++;
    endtask

    task automatic test_load_store();
        int cyc, w, u; bit to;
        logic [7:0] exp_r [4];
        fill_img();
        img[0] = 8'h3F; img[1] = 8'h42; img[2] = 8'h80; img[3] = 8'h01;
        ready_mode = 0;
        reset_and_load();
        run_program(200, cyc, w, u, to);
        exp_r[0] = 8'h00; exp_r[1] = 8'h07; exp_r[2] = 8'h07; exp_r[3] = 8'h00;
        checks++; if (to) $display("FAIL ls_timeout: got no halt want halt"); else passed++;
        checks++; if (cyc != 15) $display("FAIL ls_cycles: got %0d want 15", cyc); else passed++;
        checks++; if (wr_addr_q.size() != 1) $display("FAIL ls_write_count: got %0d want 1", wr_addr_q.size());
        else begin
            passed++;
            checks++; if (wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 8'h07)
                $display("FAIL ls_bus_write: got %h@%h want 07@00", wr_data_q[0], wr_addr_q[0]);
            else passed++;
        end
        for (int i = 0; i < 4; i++) begin
            dbg_sel = i[1:0];
            #1;
            checks++; if (dbg_data !== exp_r[i]) $display("FAIL ls_r%0d: got %h want %h", i, dbg_data, exp_r[i]); else passed++;
        end
        checks++; if (pc !== 8'h04) $display("FAIL ls_pc: got %h want 04", pc); else passed++;
        checks++; if (instret !== (INSTRET_ON ? 32'd4 : 32'd0)) $display("FAIL ls_instret: got %0d want %0d", instret, INSTRET_ON ? 4 : 0); else passed++;
    endtask

    task automatic test_pc_wrap();
        int cyc, w, u; bit to;
        fill_img();
        img[0] = 8'hE9;
        ready_mode = 0;
        reset_and_load();
        run_program(100, cyc, w, u, to);
        checks++; if (to) $display("FAIL wrap_timeout: got no halt want halt"); else passed++;
        checks++; if (cyc != 5) $display("FAIL wrap_cycles: got %0d want 5", cyc); else passed++;
        checks++; if (pc !== 8'h00) $display("FAIL wrap_pc: got %h want 00", pc); else passed++;
    endtask

    task automatic test_reset_mid_store();
        bit found;
        fill_img();
        img[0] = 8'h3F; img[1] = 8'h42; img[2] = 8'h80; img[3] = 8'h01;
        ready_mode = 2;
        reset_and_load();
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge clock);
            #1;
            if (mem_req && mem_we && !mem_ready) found = 1'b1;
        end
        checks++; if (!found) $display("FAIL mid_store_seen: got no store wait want one"); else passed++;
        reset = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) $display("FAIL mid_req_drop: got %b want 0", mem_req); else passed++;
        repeat (2) @(posedge clock);
        #1;
        dbg_sel = 2'd1;
        #1;
        checks++; if (wr_addr_q.size() != 0) $display("FAIL mid_no_write: got %0d writes want 0", wr_addr_q.size()); else passed++;
        checks++; if (mem[0] !== 8'h3F) $display("FAIL mid_mem0: got %h want 3f", mem[0]); else passed++;
        checks++; if (dbg_data !== 8'h00) $display("FAIL mid_r1: got %h want 00", dbg_data); else passed++;
        ready_mode = 0;
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'h00)
            $display("FAIL mid_refetch: got req=%b we=%b addr=%h want 1 0 00", mem_req, mem_we, mem_addr);
        else passed++;
    endtask

    task automatic test_random_programs();
        int cyc, w, u, bad; bit to, done;
        for (int it = 0; it < 12; it++) begin
            done = 1'b0;
            for (int t = 0; t < 50 && !done; t++) begin
                fill_img();
                for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
                foreach (img[i]) m_mem[i] = img[i];
                model_run(300, done);
            end
            if (!done) begin
                fill_img();
                foreach (img[i]) m_mem[i] = img[i];
                model_run(300, done);
            end
            ready_mode = $urandom_range(0, 1);
            reset_and_load();
            run_program(5000, cyc, w, u, to);
            checks++; if (to) $display("FAIL rnd%0d_timeout: got no halt want halt", it); else passed++;
            for (int i = 0; i < 4; i++) begin
                dbg_sel = i[1:0];
                #1;
                checks++; if (dbg_data !== m_reg[i]) $display("FAIL rnd%0d_r%0d: got %h want %h", it, i, dbg_data, m_reg[i]); else passed++;
            end
            checks++; if ({flag_n, flag_z} !== {m_n, m_z}) $display("FAIL rnd%0d_flags: got %b want %b", it, {flag_n, flag_z}, {m_n, m_z}); else passed++;
            checks++; if (pc !== m_pc) $display("FAIL rnd%0d_pc: got %h want %h", it, pc, m_pc); else passed++;
            checks++; if (cyc != m_cycles + w) $display("FAIL rnd%0d_cycles: got %0d want %0d", it, cyc, m_cycles + w); else passed++;
            checks++; if (instret !== (INSTRET_ON ? 32'(m_retired) : 32'd0))
                $display("FAIL rnd%0d_instret: got %0d want %0d", it, instret, INSTRET_ON ? m_retired : 0);
            else passed++;
            bad = 0;
            foreach (mem[i]) if (mem[i] !== m_mem[i]) bad++;
            checks++; if (bad != 0) $display("FAIL rnd%0d_mem: got %0d differing bytes want 0", it, bad); else passed++;
        end
        ready_mode = 0;
    endtask

    task automatic test_dw16();
        bit to;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #2 reset = 1'b0;
        to = 1'b1;
        for (int k = 0; k < 50 && to; k++) begin
            @(posedge clock);
            #1;
            if (halted16) to = 1'b0;
        end
        dbg_sel16 = 2'd0;
        #1;
        checks++; if (to) $display("FAIL dw16_timeout: got no halt want halt"); else passed++;
        checks++; if (dbg16 !== 16'hFFFF) $display("FAIL dw16_r0: got %h want ffff", dbg16); else passed++;
        checks++; if ({n16, z16} !== 2'b10) $display("FAIL dw16_flags: got %b want 10", {n16, z16}); else passed++;
        dbg_sel16 = 2'd1;
        #1;
        checks++; if (dbg16 !== 16'h0001) $display("FAIL dw16_r1: got %h want 0001", dbg16); else passed++;
        checks++; if (pc16 !== 16'h0003) $display("FAIL dw16_pc: got %h want 0003", pc16); else passed++;
    endtask

    initial begin
        foreach (mem16[i]) mem16[i] = 16'h0001;
        mem16[0] = 16'h000F;
        mem16[1] = 16'h0016;
        mem16[2] = 16'h0001;
        $display("[TB] mc_cpu_core bench starting");
        test_reset();
        test_alu_program();
        test_branch();
        test_wait_states();
        test_load_store();
        test_pc_wrap();
        test_reset_mid_store();
        test_random_programs();
        test_dw16();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
